// File: rtl/score_update_scheduler.sv
// rtl/score_update_scheduler.sv - round-robin BCD score accumulator with per-digit add sequencer
module score_update_scheduler #(
    parameter int SATURATE = 1
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       clear,
    input  logic [3:0] req,
    input  logic [7:0] pts0,
    input  logic [7:0] pts1,
    input  logic [7:0] pts2,
    input  logic [7:0] pts3,
    output logic [3:0] ack,
    output logic [3:0] digit_k,
    output logic [3:0] digit_h,
    output logic [3:0] digit_t,
    output logic [3:0] digit_u,
    output logic       busy,
    output logic       update_done,
    output logic       saturated,
    output logic       lost
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADD_U  = 3'd1,
        ADD_T  = 3'd2,
        ADD_H  = 3'd3,
        ADD_K  = 3'd4,
        COMMIT = 3'd5
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [3:0] pending;
    logic [1:0] last_grant;
    logic [7:0] pts_l;

    // Working copy of the score; the committed digits stay untouched until COMMIT
    logic [3:0] w_u;
    logic [3:0] w_t;
    logic [3:0] w_h;
    logic [3:0] w_k;
    logic       carry;

    logic       grant_found;
    logic [1:0] grant_idx;
    logic [7:0] pts_sel;
    logic       grant_en;
    logic [3:0] grant_vec;
    logic [3:0] add_a;
    logic [3:0] add_b;
    logic [4:0] add_sum;

    // Out-of-range BCD nibbles count as the largest legal digit
    function automatic logic [3:0] clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // One BCD digit add: returns {carry_out, digit}
    function automatic logic [4:0] bcd_add(input logic [3:0] a, input logic [3:0] b,
                                           input logic c);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b} + {4'b0000, c};
        if (s >= 5'd10) begin
            s = s - 5'd10;
            return {1'b1, s[3:0]};
        end
        return s;
    endfunction

    // Round-robin search: first pending bit above the previous winner, wrapping mod 4
    always_comb begin
        logic [1:0] idx;
        grant_found = 1'b0;
        grant_idx   = 2'd0;
        idx         = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_grant + 2'(k);
            if (!grant_found && pending[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    // Points of the candidate winner, taken at the grant edge
    always_comb begin
        pts_sel = pts0;
        case (grant_idx)
            2'd0:    pts_sel = pts0;
            2'd1:    pts_sel = pts1;
            2'd2:    pts_sel = pts2;
            default: pts_sel = pts3;
        endcase
    end

    // FSM state register; clear restarts the game from IDLE
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: fixed walk through the four digit adds then commit
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_found) state_nxt = ADD_U;
            ADD_U:   state_nxt = ADD_T;
            ADD_T:   state_nxt = ADD_H;
            ADD_H:   state_nxt = ADD_K;
            ADD_K:   state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: grant strobe, busy flag and the operands of the current digit add
    always_comb begin
        busy      = (state != IDLE);
        grant_en  = (state == IDLE) && grant_found;
        grant_vec = grant_en ? (4'b0001 << grant_idx) : 4'b0000;
        add_a     = 4'd0;
        add_b     = 4'd0;
        case (state)
            ADD_U: begin
                add_a = w_u;
                add_b = pts_l[3:0];
            end
            ADD_T: begin
                add_a = w_t;
                add_b = pts_l[7:4];
            end
            ADD_H:   add_a = w_h;
            ADD_K:   add_a = w_k;
            default: begin
                add_a = 4'd0;
                add_b = 4'd0;
            end
        endcase
        add_sum = bcd_add(add_a, add_b, carry);
    end

    // Datapath: pending/lost bookkeeping, grant latch, digit-serial add and commit
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pending     <= 4'd0;
            last_grant  <= 2'd3;
            lost        <= 1'b0;
            saturated   <= 1'b0;
            ack         <= 4'd0;
            update_done <= 1'b0;
            pts_l       <= 8'd0;
            carry       <= 1'b0;
            w_u         <= 4'd0;
            w_t         <= 4'd0;
            w_h         <= 4'd0;
            w_k         <= 4'd0;
            digit_u     <= 4'd0;
            digit_t     <= 4'd0;
            digit_h     <= 4'd0;
            digit_k     <= 4'd0;
        end else if (clear) begin
            pending     <= 4'd0;
            last_grant  <= 2'd3;
            lost        <= 1'b0;
            saturated   <= 1'b0;
            ack         <= 4'd0;
            update_done <= 1'b0;
            pts_l       <= 8'd0;
            carry       <= 1'b0;
            w_u         <= 4'd0;
            w_t         <= 4'd0;
            w_h         <= 4'd0;
            w_k         <= 4'd0;
            digit_u     <= 4'd0;
            digit_t     <= 4'd0;
            digit_h     <= 4'd0;
            digit_k     <= 4'd0;
        end else begin
            ack         <= grant_vec;
            update_done <= 1'b0;
            // A new strobe re-arms a bit being granted this edge; otherwise a repeat is dropped
            pending     <= (pending & ~grant_vec) | req;
            if (|(req & pending & ~grant_vec)) begin
                lost <= 1'b1;
            end
            if (grant_en) begin
                pts_l      <= {clamp9(pts_sel[7:4]), clamp9(pts_sel[3:0])};
                last_grant <= grant_idx;
                carry      <= 1'b0;
                w_u        <= digit_u;
                w_t        <= digit_t;
                w_h        <= digit_h;
                w_k        <= digit_k;
            end
            case (state)
                ADD_U: begin
                    w_u   <= add_sum[3:0];
                    carry <= add_sum[4];
                end
                ADD_T: begin
                    w_t   <= add_sum[3:0];
                    carry <= add_sum[4];
                end
                ADD_H: begin
                    w_h   <= add_sum[3:0];
                    carry <= add_sum[4];
                end
                ADD_K: begin
                    w_k   <= add_sum[3:0];
                    carry <= add_sum[4];
                end
                COMMIT: begin
                    update_done <= 1'b1;
                    // carry here is the overflow out of the thousands digit
                    if (carry) begin
                        saturated <= 1'b1;
                    end
                    if (carry && (SATURATE != 0)) begin
                        digit_u <= 4'd9;
                        digit_t <= 4'd9;
                        digit_h <= 4'd9;
                        digit_k <= 4'd9;
                    end else begin
                        digit_u <= w_u;
                        digit_t <= w_t;
                        digit_h <= w_h;
                        digit_k <= w_k;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_update_scheduler.sv
// tb/tb_score_update_scheduler.sv - scoreboard bench for score_update_scheduler
module tb_score_update_scheduler;

    logic       clk = 1'b0;
    logic       resetN;
    logic       clear;
    logic [3:0] req;
    logic [7:0] pts0, pts1, pts2, pts3;

    logic [3:0] s_ack, s_k, s_h, s_t, s_u;
    logic       s_busy, s_done, s_sat, s_lost;
    logic [3:0] w_ack, w_k, w_h, w_t, w_u;
    logic       w_busy, w_done, w_sat, w_lost;

    always #5 clk = ~clk;

    score_update_scheduler dut_s (
        .clk(clk), .resetN(resetN), .clear(clear), .req(req),
        .pts0(pts0), .pts1(pts1), .pts2(pts2), .pts3(pts3),
        .ack(s_ack), .digit_k(s_k), .digit_h(s_h), .digit_t(s_t), .digit_u(s_u),
        .busy(s_busy), .update_done(s_done), .saturated(s_sat), .lost(s_lost)
    );

    score_update_scheduler #(.SATURATE(0)) dut_w (
        .clk(clk), .resetN(resetN), .clear(clear), .req(req),
        .pts0(pts0), .pts1(pts1), .pts2(pts2), .pts3(pts3),
        .ack(w_ack), .digit_k(w_k), .digit_h(w_h), .digit_t(w_t), .digit_u(w_u),
        .busy(w_busy), .update_done(w_done), .saturated(w_sat), .lost(w_lost)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int exp_ack[$];
    int exp_sat[$];
    int exp_wrap[$];
    int ack_times[$];
    int m_sat, m_wrap;
    int last_ack_cyc, last_done_cyc, busy_cnt, drive_cyc;
    int prev_score, mon_e, mon_cur;
    bit allow_jump;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int score_of(input logic [3:0] k, input logic [3:0] h,
                                    input logic [3:0] t, input logic [3:0] u);
        return int'(k) * 1000 + int'(h) * 100 + int'(t) * 10 + int'(u);
    endfunction

    function automatic int bcd_val(input logic [7:0] p);
        int hi, lo;
        hi = (p[7:4] > 4'd9) ? 9 : int'(p[7:4]);
        lo = (p[3:0] > 4'd9) ? 9 : int'(p[3:0]);
        return hi * 10 + lo;
    endfunction

    function automatic int s_score();
        return score_of(s_k, s_h, s_t, s_u);
    endfunction

    function automatic int w_score();
        return score_of(w_k, w_h, w_t, w_u);
    endfunction

    task automatic push_event(input int i, input logic [7:0] p);
        int v;
        v = bcd_val(p);
        exp_ack.push_back(i);
        m_sat  = (m_sat + v > 9999) ? 9999 : m_sat + v;
        m_wrap = (m_wrap + v) % 10000;
        exp_sat.push_back(m_sat);
        exp_wrap.push_back(m_wrap);
    endtask

    task automatic flush_model();
        exp_ack.delete();
        exp_sat.delete();
        exp_wrap.delete();
        m_sat  = 0;
        m_wrap = 0;
    endtask

    task automatic set_pts(input int i, input logic [7:0] p);
        case (i)
            0:       pts0 = p;
            1:       pts1 = p;
            2:       pts2 = p;
            default: pts3 = p;
        endcase
    endtask

    task automatic send(input logic [3:0] mask);
        @(negedge clk);
        drive_cyc = cyc;
        req = mask;
        @(negedge clk);
        req = 4'd0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_sat.size() != 0 || exp_ack.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check("drain_timeout", exp_sat.size(), 0);
        @(negedge clk);
    endtask

    task automatic event1(input int i, input logic [7:0] p);
        set_pts(i, p);
        push_event(i, p);
        send(4'b0001 << i);
        drain(40);
    endtask

    // Monitor: pops the scoreboard on ack and update_done, watches digit stability
    always @(negedge clk) begin
        if (resetN) begin
            if (s_busy) busy_cnt++;
            if (s_ack != 4'd0) begin
                ack_times.push_back(cyc);
                last_ack_cyc = cyc;
                if (exp_ack.size() == 0) begin
                    check("unexpected_ack", s_ack, 0);
                end else begin
                    mon_e = exp_ack.pop_front();
                    check("ack_sat_inst", s_ack, 32'd1 << mon_e);
                    check("ack_wrap_inst", w_ack, 32'd1 << mon_e);
                end
            end
            if (s_done) begin
                last_done_cyc = cyc;
                if (exp_sat.size() == 0) begin
                    check("unexpected_update_done", 1, 0);
                end else begin
                    check("score_sat_inst", s_score(), exp_sat.pop_front());
                    check("score_wrap_inst", w_score(), exp_wrap.pop_front());
                    check("done_wrap_inst", w_done, 1);
                end
            end
            mon_cur = s_score();
            if (mon_cur != prev_score && !allow_jump)
                check("digits_only_on_commit", s_done, 1);
            prev_score = mon_cur;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        resetN = 1'b0; clear = 1'b0; req = 4'd0;
        pts0 = 8'd0; pts1 = 8'd0; pts2 = 8'd0; pts3 = 8'd0;
        allow_jump = 1'b1; prev_score = 0; busy_cnt = 0;
        last_ack_cyc = 0; last_done_cyc = 0; drive_cyc = 0;
        flush_model();
        repeat (3) @(negedge clk);
        check("rst_score", s_score(), 0);
        check("rst_ack", s_ack, 0);
        check("rst_busy", s_busy, 0);
        check("rst_done", s_done, 0);
        check("rst_saturated", s_sat, 0);
        check("rst_lost", s_lost, 0);
        resetN = 1'b1;
        @(negedge clk);
        allow_jump = 1'b0;

        // Single event from requester 2: latency, ack pulse width, busy length
        set_pts(2, 8'h37);
        push_event(2, 8'h37);
        busy_cnt = 0;
        ack_times.delete();
        send(4'b0100);
        drain(40);
        check("lat_ack", last_ack_cyc, drive_cyc + 2);
        check("lat_done", last_done_cyc, drive_cyc + 7);
        check("busy_cycles", busy_cnt, 5);
        check("ack_pulses", ack_times.size(), 1);
        check("score_0037", s_score(), 37);

        // Climb to 0985 then carry through tens and hundreds
        repeat (9) event1(0, 8'h99);
        event1(0, 8'h57);
        check("score_0985", s_score(), 985);
        event1(0, 8'h25);
        check("score_1010", s_score(), 1010);

        // Request held across its own grant edge: re-armed, not dropped
        set_pts(2, 8'h01);
        push_event(2, 8'h01);
        push_event(2, 8'h01);
        @(negedge clk); req = 4'b0100;
        @(negedge clk);
        @(negedge clk); req = 4'd0;
        drain(60);
        check("setwins_lost", s_lost, 0);
        check("score_1012", s_score(), 1012);

        // Nibbles above 9 clamp to 9
        event1(3, 8'hAF);
        check("score_clamp", s_score(), 1111);

        // Second strobe while pending[1] still set is dropped
        set_pts(0, 8'h01);
        set_pts(1, 8'h02);
        push_event(0, 8'h01);
        push_event(1, 8'h02);
        @(negedge clk); req = 4'b0001;
        @(negedge clk); req = 4'd0;
        @(negedge clk); req = 4'b0010;
        @(negedge clk); req = 4'd0;
        @(negedge clk); req = 4'b0010;
        @(negedge clk); req = 4'd0;
        drain(60);
        check("lost_set", s_lost, 1);
        check("score_1114", s_score(), 1114);

        // clear wipes score and sticky flags
        allow_jump = 1'b1;
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        flush_model();
        @(negedge clk); allow_jump = 1'b0;
        check("clear_score", s_score(), 0);
        check("clear_lost", s_lost, 0);
        check("clear_busy", s_busy, 0);

        // All four at once: round-robin order from requester 0, six cycles apart
        for (int i = 0; i < 4; i++) begin
            set_pts(i, 8'h01);
            push_event(i, 8'h01);
        end
        ack_times.delete();
        @(negedge clk); req = 4'hF;
        @(negedge clk); req = 4'd0;
        drain(80);
        check("rr_ack_count", ack_times.size(), 4);
        if (ack_times.size() == 4)
            for (int i = 1; i < 4; i++)
                check("rr_ack_gap", ack_times[i] - ack_times[i-1], 6);
        check("rr_score", s_score(), 4);
        check("rr_lost", s_lost, 0);

        // Overflow: clamp in one instance, wrap in the other
        repeat (100) event1(1, 8'h99);
        event1(1, 8'h86);
        check("score_9990", s_score(), 9990);
        check("presat_flag", s_sat, 0);
        event1(1, 8'h15);
        check("sat_score", s_score(), 9999);
        check("sat_flag", s_sat, 1);
        check("wrap_score", w_score(), 5);
        check("wrap_flag", w_sat, 1);
        event1(1, 8'h01);
        check("sat_hold", s_score(), 9999);
        check("wrap_6", w_score(), 6);

        // clear while in ADD_H aborts the add
        set_pts(3, 8'h11);
        push_event(3, 8'h11);
        @(negedge clk); req = 4'b1000;
        @(negedge clk); req = 4'd0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); allow_jump = 1'b1; clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        check("clear_ack_seen", exp_ack.size(), 0);
        flush_model();
        @(negedge clk); allow_jump = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_clear_score", s_score(), 0);
        check("abort_clear_wrap", w_score(), 0);
        check("abort_clear_busy", s_busy, 0);
        check("abort_clear_sat", s_sat, 0);
        event1(0, 8'h42);
        check("after_clear_score", s_score(), 42);

        // Asynchronous reset while in ADD_T
        set_pts(2, 8'h05);
        push_event(2, 8'h05);
        @(negedge clk); req = 4'b0100;
        @(negedge clk); req = 4'd0;
        @(negedge clk);
        @(negedge clk); allow_jump = 1'b1; resetN = 1'b0;
        check("reset_ack_seen", exp_ack.size(), 0);
        flush_model();
        #1;
        check("async_rst_busy", s_busy, 0);
        check("async_rst_score", s_score(), 0);
        @(negedge clk); resetN = 1'b1;
        @(negedge clk); allow_jump = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_rst_score", s_score(), 0);
        check("abort_rst_busy", s_busy, 0);
        event1(2, 8'h05);
        check("after_rst_score", s_score(), 5);
        check("final_queue", exp_sat.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
